// File: rtl/gba_rom_loader.sv
// Packs the IO loader byte stream into little-endian halfwords, buffers them in a
// small FIFO and writes them to SDRAM at a mode-dependent base through a req/ack port.
module gba_rom_loader #(
  parameter logic [25:0] BASE_ROM     = 26'h0000000,
  parameter logic [25:0] ROM_MAX      = 26'h2000000,
  parameter logic [25:0] BASE_CARTRAM = 26'h2010000,
  parameter logic [25:0] CARTRAM_MAX  = 26'h0020000,
  parameter logic [25:0] BASE_BIOS    = 26'h2000000,
  parameter logic [25:0] BIOS_MAX     = 26'h0004000,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [25:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        loading,
  output logic        load_done,
  output logic [25:0] rom_size,
  output logic        overflow,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  typedef struct packed {
    logic [25:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } entry_t;

  // Memory port: mem_req is a level held with addr/wdata/be stable until the
  // cycle mem_ack is sampled high; the entry leaves the FIFO when it is launched,
  // so the output register is one extra slot of buffering.
  state_t      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [25:0] base_q, base_d;
  logic [25:0] max_q, max_d;
  logic [25:0] count_q, count_d;
  logic [7:0]  partial_q, partial_d;
  logic        overflow_q, overflow_d;
  logic [25:0] rom_size_q, rom_size_d;
  logic        req_q, req_d;
  logic [25:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;

  entry_t      fifo_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full, pop, push_en, push_ok, start_load, wr_mode;
  entry_t      push_entry, head;
  logic [25:0] sel_base, sel_max, hw_addr;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head       = fifo_q[rd_ptr_q[PW-1:0]];
  assign pop        = !fifo_empty && (!req_q || mem_ack);
  assign wr_mode    = (mode_q == 3'd1) || (mode_q == 3'd2) || (mode_q == 3'd4);
  assign hw_addr    = base_q + {count_q[25:1], 1'b0};

  // Non-writing modes count without a limit other than the counter width.
  always_comb begin
    sel_base = 26'd0;
    sel_max  = '1;
    case (rom_loading)
      3'd1: begin sel_base = BASE_ROM;     sel_max = ROM_MAX;     end
      3'd2: begin sel_base = BASE_CARTRAM; sel_max = CARTRAM_MAX; end
      3'd4: begin sel_base = BASE_BIOS;    sel_max = BIOS_MAX;    end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    base_d     = base_q;
    max_d      = max_q;
    count_d    = count_q;
    partial_d  = partial_q;
    overflow_d = overflow_q;
    rom_size_d = rom_size_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    push_en    = 1'b0;
    push_entry = '0;
    start_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rom_loading != 3'd0) begin
          start_load = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (rom_loading != mode_q) begin
          state_d = S_FLUSH;
          if (rom_do_valid) overflow_d = 1'b1;
          if (count_q[0] && wr_mode) begin
            push_en    = 1'b1;
            push_entry = '{addr: hw_addr, data: {8'h00, partial_q}, be: 2'b01};
          end
        end else if (rom_do_valid) begin
          if (count_q < max_q) begin
            count_d = count_q + 26'd1;
            if (!count_q[0]) begin
              partial_d = rom_do;
            end else if (wr_mode) begin
              push_en    = 1'b1;
              push_entry = '{addr: hw_addr, data: {rom_do, partial_q}, be: 2'b11};
            end
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (rom_do_valid) overflow_d = 1'b1;
        if (fifo_empty && !req_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (mode_q == 3'd1) rom_size_d = count_q;
        if (rom_loading != 3'd0) begin
          start_load = 1'b1;
          state_d    = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = push_en && (!fifo_full || pop);
    if (push_en && !push_ok) overflow_d = 1'b1;

    if (start_load) begin
      mode_d     = rom_loading;
      base_d     = sel_base;
      max_d      = sel_max;
      count_d    = 26'd0;
      partial_d  = 8'h00;
      overflow_d = 1'b0;
    end

    if (pop) begin
      req_d   = 1'b1;
      addr_d  = head.addr;
      wdata_d = head.data;
      be_d    = head.be;
    end else if (req_q && mem_ack) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      mode_q     <= 3'd0;
      base_q     <= 26'd0;
      max_q      <= 26'd0;
      count_q    <= 26'd0;
      partial_q  <= 8'h00;
      overflow_q <= 1'b0;
      rom_size_q <= 26'd0;
      req_q      <= 1'b0;
      addr_q     <= 26'd0;
      wdata_q    <= 16'd0;
      be_q       <= 2'b00;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      base_q     <= base_d;
      max_q      <= max_d;
      count_q    <= count_d;
      partial_q  <= partial_d;
      overflow_q <= overflow_d;
      rom_size_q <= rom_size_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push_ok) begin
        fifo_q[wr_ptr_q[PW-1:0]] <= push_entry;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign loading   = (state_q != S_IDLE);
  assign load_done = (state_q == S_DONE);
  assign rom_size  = rom_size_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gba_rom_loader.sv
// Directed bench for gba_rom_loader: an SDRAM responder with configurable ack
// latency records writes, which are compared against hand-computed expectations.
module tb_gba_rom_loader;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  rom_loading;
  logic [7:0]  rom_do;
  logic        rom_do_valid;
  logic        mem_req;
  logic        mem_ack;
  logic [25:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        loading;
  logic        load_done;
  logic [25:0] rom_size;
  logic        overflow;
  logic [1:0]  dbg_state;

  gba_rom_loader dut (
    .clk(clk), .resetn(resetn), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .loading(loading), .load_done(load_done), .rom_size(rom_size),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int req_cnt  = 0;
  int ack_delay = 2;
  int wait_cnt  = 0;
  logic ack_hold = 1'b0;
  logic [43:0] exp_q[$];
  logic [43:0] got_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SDRAM responder: ack arrives ack_delay+1 cycles after a request is seen.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!resetn || !mem_req || ack_hold) begin
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack  = 1'b1;
      wait_cnt = 0;
    end else begin
      wait_cnt++;
    end
  end

  always @(posedge clk) begin
    if (resetn && mem_req && mem_ack) got_q.push_back({mem_addr, mem_wdata, mem_be});
    if (resetn && load_done) done_cnt++;
    if (resetn && mem_req) req_cnt++;
  end

  task automatic start_mode(input logic [2:0] m);
    @(negedge clk);
    rom_loading = m;
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rom_do       = b;
    rom_do_valid = 1'b1;
  endtask

  task automatic end_load(input logic [2:0] m_next);
    @(negedge clk);
    rom_do_valid = 1'b0;
    rom_loading  = m_next;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rom_do_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    check_eq({tag, "_done"}, done_cnt, target);
  endtask

  task automatic exp_hw(input logic [25:0] a, input logic [15:0] d, input logic [1:0] be);
    exp_q.push_back({a, d, be});
  endtask

  task automatic check_writes(input string tag);
    int n;
    check_eq({tag, "_nwrites"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_write"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t;
    logic [7:0] b0, b1;
    resetn = 1'b0; rom_loading = 3'd0; rom_do = 8'h00; rom_do_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_be", mem_be, 0);
    check_eq("rst_loading", loading, 0);
    check_eq("rst_done", load_done, 0);
    check_eq("rst_size", rom_size, 0);
    check_eq("rst_ovf", overflow, 0);
    resetn = 1'b1;
    idle_cycles(2);

    // Mode 1, four bytes
    ack_delay = 2;
    t = done_cnt + 1;
    start_mode(3'd1);
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    end_load(3'd0);
    wait_done("t1", t, 200);
    idle_cycles(2);
    exp_hw(26'h0000000, 16'h0201, 2'b11);
    exp_hw(26'h0000002, 16'h0403, 2'b11);
    check_writes("t1");
    check_eq("t1_ndone", done_cnt, t);
    check_eq("t1_size", rom_size, 4);
    check_eq("t1_ovf", overflow, 0);

    // Mode 4, odd length with flush entry
    t = done_cnt + 1;
    start_mode(3'd4);
    put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD); put(8'hEE);
    end_load(3'd0);
    wait_done("t2", t, 200);
    idle_cycles(2);
    exp_hw(26'h2000000, 16'hBBAA, 2'b11);
    exp_hw(26'h2000002, 16'hDDCC, 2'b11);
    exp_hw(26'h2000004, 16'h00EE, 2'b01);
    check_writes("t2");
    check_eq("t2_size", rom_size, 4);
    check_eq("t2_ovf", overflow, 0);

    // Mode 1, acks withheld: 8 FIFO entries + 1 in flight survive
    t = done_cnt + 1;
    ack_hold = 1'b1;
    start_mode(3'd1);
    for (int i = 0; i < 24; i++) put(8'(i));
    idle_cycles(16);
    check_eq("t3a_ovf_hold", overflow, 1);
    ack_hold = 1'b0;
    end_load(3'd0);
    wait_done("t3a", t, 300);
    idle_cycles(2);
    for (int k = 0; k < 9; k++) exp_hw(26'(2 * k), {8'(2 * k + 1), 8'(2 * k)}, 2'b11);
    check_writes("t3a");
    check_eq("t3a_ovf", overflow, 1);
    check_eq("t3a_size", rom_size, 24);

    // Same stream with prompt acks
    t = done_cnt + 1;
    start_mode(3'd1);
    for (int i = 0; i < 24; i++) put(8'(i));
    end_load(3'd0);
    wait_done("t3b", t, 300);
    idle_cycles(2);
    for (int k = 0; k < 12; k++) exp_hw(26'(2 * k), {8'(2 * k + 1), 8'(2 * k)}, 2'b11);
    check_writes("t3b");
    check_eq("t3b_ovf", overflow, 0);

    // Mode 4, 16 KiB + 2 bytes
    ack_delay = 0;
    t = done_cnt + 1;
    start_mode(3'd4);
    for (int i = 0; i < 16386; i++) put(8'(i));
    end_load(3'd0);
    wait_done("t4", t, 300);
    idle_cycles(2);
    for (int k = 0; k < 8192; k++) begin
      b0 = 8'(2 * k);
      b1 = 8'(2 * k + 1);
      exp_hw(26'h2000000 + 26'(2 * k), {b1, b0}, 2'b11);
    end
    if (got_q.size() > 0) check_eq("t4_last_addr", got_q[got_q.size() - 1][43:18], 26'h2003FFE);
    check_writes("t4");
    check_eq("t4_ovf", overflow, 1);
    check_eq("t4_size", rom_size, 24);

    // Reset while a request is outstanding
    ack_delay = 2;
    ack_hold  = 1'b1;
    start_mode(3'd1);
    put(8'h55); put(8'h66); put(8'h77); put(8'h88);
    idle_cycles(1);
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    check_eq("t5_req_before", mem_req, 1);
    @(negedge clk);
    resetn = 1'b0;
    rom_loading = 3'd0;
    #1;
    check_eq("t5_req_rst", mem_req, 0);
    check_eq("t5_loading_rst", loading, 0);
    @(negedge clk);
    resetn   = 1'b1;
    ack_hold = 1'b0;
    got_q.delete();
    idle_cycles(3);
    check_eq("t5_idle_loading", loading, 0);
    check_eq("t5_idle_state", dbg_state, 0);
    t = done_cnt + 1;
    start_mode(3'd1);
    put(8'h11); put(8'h22);
    end_load(3'd0);
    wait_done("t5", t, 200);
    idle_cycles(2);
    exp_hw(26'h0000000, 16'h2211, 2'b11);
    check_writes("t5");

    // Mode 1 -> 3 directly after three bytes
    t = done_cnt + 1;
    start_mode(3'd1);
    put(8'h5A); put(8'h6B); put(8'h7C);
    end_load(3'd3);
    wait_done("t6a", t, 200);
    req_cnt = 0;
    @(negedge clk);
    check_eq("t6_size", rom_size, 3);
    check_eq("t6_loading3", loading, 1);
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    end_load(3'd0);
    wait_done("t6b", t + 1, 200);
    idle_cycles(2);
    exp_hw(26'h0000000, 16'h6B5A, 2'b11);
    exp_hw(26'h0000002, 16'h007C, 2'b01);
    check_writes("t6");
    check_eq("t6_mode3_req", req_cnt, 0);
    check_eq("t6_size_after3", rom_size, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule

// File: doc/gba_rom_loader.md
Name: gba_rom_loader

Overview:
Consumes the byte stream that the IO subsystem emits during ROM, cart-RAM and BIOS loading (rom_loading / rom_do / rom_do_valid). It packs the bytes into little-endian 16-bit halfwords and buffers them in a small FIFO. It then writes them into SDRAM at a mode-dependent base address through a req/ack port. On completion it reports the loaded size and pulses a done strobe to the GBA core.

Parameters:
BASE_ROM, 26'h0000000, byte base address for mode 1 (cart ROM)
ROM_MAX, 26'h2000000, max accepted bytes in mode 1 (32 MiB)
BASE_CARTRAM, 26'h2010000, byte base for mode 2 (backup RAM image)
CARTRAM_MAX, 26'h0020000, max bytes in mode 2 (128 KiB)
BASE_BIOS, 26'h2000000, byte base for mode 4 (BIOS)
BIOS_MAX, 26'h0004000, max bytes in mode 4 (16 KiB)
FIFO_DEPTH, 8, halfword FIFO entries (power of two, at least 4)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rom_loading  in  3  load mode: 0 idle, 1 ROM, 2 cart RAM, 3 config, 4 BIOS
rom_do  in  8  load byte
rom_do_valid  in  1  one-cycle strobe per byte; back-to-back cycles allowed
mem_req  out  1  SDRAM write request, level
mem_ack  in  1  one-cycle completion pulse
mem_addr  out  26  byte address; bit 0 always 0
mem_wdata  out  16  {odd byte, even byte}
mem_be  out  2  byte enables {hi, lo}
loading  out  1  high while state is not IDLE
load_done  out  1  one-cycle pulse at end of a load
rom_size  out  26  bytes accepted in the last completed mode-1 load
overflow  out  1  sticky error flag; cleared at the start of each load

Behaviour:
- Reset (async): state IDLE; mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, loading=0, load_done=0, rom_size=0, overflow=0. FIFO, byte counter and partial-byte register are cleared. A reset mid-transfer drops mem_req immediately. The write in flight is abandoned.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE -> LOAD: rom_loading goes nonzero. On this transition the block latches the mode, clears the byte count, clears overflow, and selects base/max from the mode.
- LOAD: every rom_do_valid with count < max accepts the byte and increments count.
  - Even-offset byte goes to the partial register.
  - Odd-offset byte completes a halfword {rom_do, partial} with be=2'b11 and pushes it to the FIFO.
  - A byte with count >= max is discarded and sets overflow.
  - Modes 3, 5, 6, 7: bytes are counted, nothing is pushed, and no SDRAM writes occur.
- FIFO push when full: the halfword is dropped and overflow is set. A push and pop in the same cycle on a full FIFO is legal and loses nothing.
- Write address = base + 2*(halfword index). The address is computed at push time and stored with the entry.
- LOAD -> FLUSH: rom_loading returns to 0, or changes to a different nonzero code.
  - If count is odd, push the final entry {8'h00, partial} with be=2'b01.
  - rom_do_valid during FLUSH is ignored and sets overflow.
- FLUSH -> DONE: FIFO is empty and no request is outstanding.
- DONE: load_done=1 for exactly one cycle. If the mode was 1, rom_size is updated to count.
  - If rom_loading is now nonzero, go to LOAD with the new mode. This is handled like the IDLE->LOAD transition, so overflow is cleared again.
  - Otherwise go to IDLE.
- Memory handshake:
  - When the FIFO is non-empty and no request is outstanding, assert mem_req with mem_addr/mem_wdata/mem_be taken from the FIFO head.
  - Hold these values stable until mem_ack. mem_ack is honoured only while mem_req=1.
  - On mem_ack, pop the entry. mem_req may stay high in the next cycle with the next entry.
  - mem_ack while mem_req=0 is ignored.
- Sustained throughput: 4 bytes per firmware store produce 2 halfwords within 4 cycles. The FIFO absorbs these while SDRAM latency is ≤ FIFO_DEPTH/2 ack periods per word.
- Count width is 26 bits. The count saturates at max and does not wrap.

Test Plan:
- Mode 1, bytes 01 02 03 04, rom_loading->0, mem_ack 3 cycles after each req. Required: writes (0x0000000, 0x0201, be=11) and (0x0000002, 0x0403, be=11), one load_done pulse, rom_size=4, overflow=0.
- Mode 4, 5 bytes AA BB CC DD EE, then end. Required: writes at 0x2000000 and 0x2000002 with be=11, then at 0x2000004 with data 0x00EE and be=01; rom_size stays at its previous value.
- Mode 1 with mem_ack withheld for 40 cycles while 24 back-to-back bytes arrive. Required: the first 9 halfwords are retained (8 FIFO entries + 1 in flight), the remainder are dropped, and overflow=1. With acks prompt (≤ 3 cycles) and the same stream, overflow=0 and all 12 writes complete in order.
- Mode 4 with 16 KiB + 2 bytes. Required: 8192 writes, last address 0x2003FFE, the 2 extra bytes discarded, overflow=1.
- Reset asserted while mem_req=1 mid-load. Required: the same cycle shows mem_req=0 and loading=0; after release the block sits in IDLE; a new mode-1 load writes from 0x0000000.
- rom_loading 1->3 directly after 3 bytes. Required: a flush write (0x0000002, 0x00xx, be=01), load_done pulse, rom_size=3, then a mode-3 load with no mem_req.
